// File: rtl/pipe_hazard_ctrl_if.sv
// Stage metadata in, pipeline control and performance counters out.
// The master side is the datapath and the slave side is the hazard controller.
interface pipe_hazard_ctrl_if #(
  parameter int CNT_WIDTH = 32
);
  logic                 D_valid;
  logic [4:0]           D_rs1;
  logic [4:0]           D_rs2;
  logic                 D_uses_rs1;
  logic                 D_uses_rs2;
  logic                 E_valid;
  logic [4:0]           E_rd;
  logic                 E_wb_en;
  logic                 E_mem_read_en;
  logic                 e_cond;
  logic                 M_valid;
  logic [4:0]           M_rd;
  logic                 M_wb_en;
  logic                 W_valid;
  logic [4:0]           W_rd;
  logic                 W_wb_en;
  logic                 fault;

  logic                 pc_stall;
  logic                 D_stall;
  logic                 D_bubble;
  logic                 E_bubble;
  logic                 M_bubble;
  logic                 W_bubble;
  logic [1:0]           fwd_a;
  logic [1:0]           fwd_b;
  logic                 running;
  logic                 halted;
  logic [CNT_WIDTH-1:0] cycle_count;
  logic [CNT_WIDTH-1:0] retire_count;
  logic [CNT_WIDTH-1:0] stall_count;

  modport master (
    output D_valid, D_rs1, D_rs2, D_uses_rs1, D_uses_rs2,
    output E_valid, E_rd, E_wb_en, E_mem_read_en, e_cond,
    output M_valid, M_rd, M_wb_en, W_valid, W_rd, W_wb_en, fault,
    input  pc_stall, D_stall, D_bubble, E_bubble, M_bubble, W_bubble,
    input  fwd_a, fwd_b, running, halted,
    input  cycle_count, retire_count, stall_count
  );

  modport slave (
    input  D_valid, D_rs1, D_rs2, D_uses_rs1, D_uses_rs2,
    input  E_valid, E_rd, E_wb_en, E_mem_read_en, e_cond,
    input  M_valid, M_rd, M_wb_en, W_valid, W_rd, W_wb_en, fault,
    output pc_stall, D_stall, D_bubble, E_bubble, M_bubble, W_bubble,
    output fwd_a, fwd_b, running, halted,
    output cycle_count, retire_count, stall_count
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller for a 5-stage RV32I pipeline: forwarding, load-use stall,
// branch flush, post-reset flush sequencing, fault freeze and perf counters.
module pipe_hazard_ctrl #(
  parameter int XLEN        = 32,
  parameter int CNT_WIDTH   = 32,
  parameter int INIT_CYCLES = 4
) (
  input logic                clock,
  input logic                reset,
  pipe_hazard_ctrl_if.slave  hz
);

  if (INIT_CYCLES < 1 || INIT_CYCLES > 15 || XLEN < 1) begin : g_param_chk
    $error("pipe_hazard_ctrl: INIT_CYCLES must be 1..15 and XLEN positive");
  end

  typedef enum logic [1:0] {INIT, RUN, HALT} state_t;

  localparam logic [3:0] INIT_LAST = 4'(INIT_CYCLES - 1);

  state_t               state, state_nxt;
  logic [3:0]           init_cnt;
  logic [CNT_WIDTH-1:0] cycle_q, retire_q, stall_q;

  logic       m_e1, m_m1, m_w1, m_e2, m_m2, m_w2;
  logic       load_use, wb_fault;
  logic [1:0] sel_a, sel_b;

  function automatic logic match(input logic [4:0] src, input logic vld,
                                 input logic wb, input logic [4:0] rd);
    return vld && wb && (rd == src) && (src != 5'd0);
  endfunction

  always_comb begin
    m_e1 = match(hz.D_rs1, hz.E_valid, hz.E_wb_en, hz.E_rd);
    m_m1 = match(hz.D_rs1, hz.M_valid, hz.M_wb_en, hz.M_rd);
    m_w1 = match(hz.D_rs1, hz.W_valid, hz.W_wb_en, hz.W_rd);
    m_e2 = match(hz.D_rs2, hz.E_valid, hz.E_wb_en, hz.E_rd);
    m_m2 = match(hz.D_rs2, hz.M_valid, hz.M_wb_en, hz.M_rd);
    m_w2 = match(hz.D_rs2, hz.W_valid, hz.W_wb_en, hz.W_rd);

    // Youngest producer wins: E over M over W.
    sel_a = 2'd0;
    if (hz.D_uses_rs1) begin
      if (m_e1)      sel_a = 2'd1;
      else if (m_m1) sel_a = 2'd2;
      else if (m_w1) sel_a = 2'd3;
    end
    sel_b = 2'd0;
    if (hz.D_uses_rs2) begin
      if (m_e2)      sel_b = 2'd1;
      else if (m_m2) sel_b = 2'd2;
      else if (m_w2) sel_b = 2'd3;
    end

    load_use = hz.D_valid && hz.E_mem_read_en &&
               ((hz.D_uses_rs1 && m_e1) || (hz.D_uses_rs2 && m_e2));
    wb_fault = hz.W_valid && hz.fault;
  end

  always_comb begin
    state_nxt   = state;
    hz.pc_stall = 1'b0;
    hz.D_stall  = 1'b0;
    hz.D_bubble = 1'b0;
    hz.E_bubble = 1'b0;
    hz.M_bubble = 1'b0;
    hz.W_bubble = 1'b0;
    hz.fwd_a    = 2'd0;
    hz.fwd_b    = 2'd0;
    hz.running  = 1'b0;
    hz.halted   = 1'b0;

    if (reset || state == INIT) begin
      // Flush every stage while the pipeline fills with known-empty slots.
      hz.pc_stall = 1'b1;
      hz.D_bubble = 1'b1;
      hz.E_bubble = 1'b1;
      hz.M_bubble = 1'b1;
      hz.W_bubble = 1'b1;
      if (!reset && init_cnt == INIT_LAST) state_nxt = RUN;
    end else begin
      case (state)
        RUN: begin
          hz.running = 1'b1;
          hz.fwd_a   = sel_a;
          hz.fwd_b   = sel_b;
          // A taken branch discards the dependent instruction, so no stall.
          if (hz.e_cond) begin
            hz.D_bubble = 1'b1;
            hz.E_bubble = 1'b1;
          end else if (load_use) begin
            hz.pc_stall = 1'b1;
            hz.D_stall  = 1'b1;
            hz.E_bubble = 1'b1;
          end
          if (wb_fault) begin
            hz.pc_stall = 1'b1;
            hz.D_stall  = 1'b1;
            hz.D_bubble = 1'b0;
            hz.E_bubble = 1'b1;
            hz.M_bubble = 1'b1;
            hz.W_bubble = 1'b1;
            state_nxt   = HALT;
          end
        end
        HALT: begin
          hz.halted   = 1'b1;
          hz.pc_stall = 1'b1;
          hz.D_stall  = 1'b1;
          hz.E_bubble = 1'b1;
          hz.M_bubble = 1'b1;
          hz.W_bubble = 1'b1;
        end
        default: state_nxt = INIT;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= INIT;
      init_cnt <= 4'd0;
      cycle_q  <= '0;
      retire_q <= '0;
      stall_q  <= '0;
    end else begin
      state <= state_nxt;
      if (state == INIT) init_cnt <= init_cnt + 4'd1;
      if (state == RUN) begin
        cycle_q <= cycle_q + 1'b1;
        if (hz.W_valid && !hz.fault) retire_q <= retire_q + 1'b1;
        if (load_use && !hz.e_cond)  stall_q  <= stall_q + 1'b1;
      end
    end
  end

  assign hz.cycle_count  = cycle_q;
  assign hz.retire_count = retire_q;
  assign hz.stall_count  = stall_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: a 32-bit counter instance for function
// and a 4-bit counter instance for wrap-around.
module tb_pipe_hazard_ctrl;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic reset4 = 1'b1;
  int   total = 0;
  int   passes = 0;

  always #5 clock = ~clock;

  pipe_hazard_ctrl_if #(.CNT_WIDTH(32)) bus ();
  pipe_hazard_ctrl_if #(.CNT_WIDTH(4))  bus4 ();

  pipe_hazard_ctrl #(.XLEN(32), .CNT_WIDTH(32), .INIT_CYCLES(4)) dut (
    .clock(clock), .reset(reset), .hz(bus.slave));
  pipe_hazard_ctrl #(.XLEN(32), .CNT_WIDTH(4), .INIT_CYCLES(4)) dut4 (
    .clock(clock), .reset(reset4), .hz(bus4.slave));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    bus.D_valid = 0; bus.D_rs1 = 0; bus.D_rs2 = 0; bus.D_uses_rs1 = 0; bus.D_uses_rs2 = 0;
    bus.E_valid = 0; bus.E_rd = 0; bus.E_wb_en = 0; bus.E_mem_read_en = 0; bus.e_cond = 0;
    bus.M_valid = 0; bus.M_rd = 0; bus.M_wb_en = 0;
    bus.W_valid = 0; bus.W_rd = 0; bus.W_wb_en = 0; bus.fault = 0;
  endtask

  initial begin
    clear_inputs();
    bus4.D_valid = 0; bus4.D_rs1 = 0; bus4.D_rs2 = 0; bus4.D_uses_rs1 = 0; bus4.D_uses_rs2 = 0;
    bus4.E_valid = 0; bus4.E_rd = 0; bus4.E_wb_en = 0; bus4.E_mem_read_en = 0; bus4.e_cond = 0;
    bus4.M_valid = 0; bus4.M_rd = 0; bus4.M_wb_en = 0;
    bus4.W_valid = 1; bus4.W_rd = 0; bus4.W_wb_en = 0; bus4.fault = 0;

    // Reset for two cycles
    tick(); tick();
    check("rst_pc_stall", bus.pc_stall, 1);
    check("rst_bubbles", {bus.D_bubble, bus.E_bubble, bus.M_bubble, bus.W_bubble}, 4'hF);
    check("rst_d_stall", bus.D_stall, 0);
    check("rst_running", {bus.running, bus.halted}, 0);
    check("rst_cycles", bus.cycle_count, 0);
    reset = 0;
    for (int i = 0; i < 4; i++) begin
      check("init_flush", {bus.pc_stall, bus.D_bubble, bus.W_bubble, bus.running}, 4'b1110);
      tick();
    end
    check("run_entry", bus.running, 1);
    check("run_pc_stall", bus.pc_stall, 0);
    check("run_counters", bus.cycle_count | bus.retire_count | bus.stall_count, 0);

    // Forwarding priority
    bus.E_valid = 1; bus.E_rd = 5; bus.E_wb_en = 1;
    bus.M_valid = 1; bus.M_rd = 5; bus.M_wb_en = 1;
    bus.D_valid = 1; bus.D_rs1 = 5; bus.D_uses_rs1 = 1;
    #1 check("fwd_a_E", bus.fwd_a, 1);
    check("fwd_b_unused", bus.fwd_b, 0);
    bus.E_valid = 0;
    #1 check("fwd_a_M", bus.fwd_a, 2);
    bus.M_valid = 0; bus.W_valid = 1; bus.W_rd = 5; bus.W_wb_en = 1;
    #1 check("fwd_a_W", bus.fwd_a, 3);
    bus.D_uses_rs1 = 0;
    #1 check("fwd_a_gated", bus.fwd_a, 0);
    bus.D_uses_rs1 = 1; bus.D_rs1 = 0; bus.E_valid = 1; bus.E_rd = 0; bus.M_valid = 1; bus.M_rd = 0;
    bus.W_rd = 0;
    #1 check("fwd_a_x0", bus.fwd_a, 0);
    bus.D_rs2 = 9; bus.D_uses_rs2 = 1; bus.M_rd = 9;
    #1 check("fwd_b_M", bus.fwd_b, 2);
    clear_inputs();
    tick();                                   // cycle 1

    // Load-use: one stall cycle, then load forwarded from M
    bus.E_valid = 1; bus.E_rd = 7; bus.E_wb_en = 1; bus.E_mem_read_en = 1;
    bus.D_valid = 1; bus.D_rs2 = 7; bus.D_uses_rs2 = 1;
    #1 check("lu_stall", {bus.pc_stall, bus.D_stall, bus.E_bubble, bus.D_bubble}, 4'b1110);
    tick();                                   // cycle 2, stall 1
    bus.E_valid = 0; bus.E_wb_en = 0; bus.E_mem_read_en = 0;
    bus.M_valid = 1; bus.M_rd = 7; bus.M_wb_en = 1;
    #1 check("lu_fwd_b_M", bus.fwd_b, 2);
    check("lu_no_stall", {bus.pc_stall, bus.D_stall, bus.E_bubble}, 0);
    check("lu_stall_count", bus.stall_count, 1);
    check("lu_cycle_count", bus.cycle_count, 2);

    // Taken branch overrides the load-use stall
    bus.E_valid = 1; bus.E_wb_en = 1; bus.E_mem_read_en = 1; bus.e_cond = 1;
    #1 check("br_flush", {bus.pc_stall, bus.D_stall, bus.D_bubble, bus.E_bubble}, 4'b0011);
    tick();                                   // cycle 3, no stall counted
    check("br_stall_count", bus.stall_count, 1);
    clear_inputs();

    // Retirement
    bus.W_valid = 1;
    tick(); tick(); tick();                   // cycles 4..6, retire 3
    check("ret_count", bus.retire_count, 3);
    check("ret_cycles", bus.cycle_count, 6);

    // Write-back fault freezes the pipe
    bus.fault = 1;
    #1 check("flt_freeze", {bus.pc_stall, bus.D_stall, bus.E_bubble, bus.M_bubble, bus.W_bubble}, 5'h1F);
    check("flt_not_halted", bus.halted, 0);
    tick();                                   // cycle 7, no retire
    check("flt_halted", {bus.halted, bus.running}, 2'b10);
    check("flt_retire", bus.retire_count, 3);
    check("flt_cycles", bus.cycle_count, 7);
    bus.fault = 0;
    bus.E_valid = 1; bus.E_rd = 7; bus.E_wb_en = 1; bus.E_mem_read_en = 1;
    bus.D_valid = 1; bus.D_rs1 = 7; bus.D_uses_rs1 = 1;
    repeat (20) tick();
    check("halt_cycles", bus.cycle_count, 7);
    check("halt_retire", bus.retire_count, 3);
    check("halt_stalls", bus.stall_count, 1);
    check("halt_freeze", {bus.halted, bus.pc_stall, bus.D_stall, bus.E_bubble, bus.M_bubble, bus.W_bubble}, 6'h3F);
    check("halt_fwd", {bus.fwd_a, bus.fwd_b}, 0);
    check("halt_no_dbubble", bus.D_bubble, 0);

    // Reset leaves HALT; fault is ignored during INIT
    clear_inputs();
    bus.W_valid = 1; bus.fault = 1;
    reset = 1;
    tick();
    check("rst2_counters", bus.cycle_count | bus.retire_count | bus.stall_count, 0);
    check("rst2_state", {bus.running, bus.halted}, 0);
    reset = 0;
    tick(); tick(); tick(); tick();
    check("init_fault_ignored", {bus.running, bus.halted}, 2'b10);
    check("init_no_retire", bus.retire_count, 0);
    bus.fault = 0;
    #1 check("rerun_no_freeze", bus.pc_stall, 0);

    // Counter wrap on the 4-bit instance
    reset4 = 0;
    tick(); tick(); tick(); tick();
    check("wrap_running", bus4.running, 1);
    repeat (17) tick();
    check("wrap_cycles", bus4.cycle_count, 1);
    check("wrap_retire", bus4.retire_count, 1);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
